// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Polyphony manager. Note-on/note-off events are accepted one at a time and
// mapped onto NUM_VOICES synthesis voices. Each event takes three cycles:
// IDLE (accept) -> LOOKUP (pick target + action) -> APPLY (update voices).
//
// Note-on target choice, first rule that applies:
//   retrigger a gated voice with the same note, else the lowest free voice,
//   else the oldest releasing voice, else steal the oldest gated voice.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   note_valid/ready  event handshake; an event transfers on a cycle where
//                     both are high. ready is high only in IDLE. valid may
//                     stay high back-to-back; each event waits for ready.
//   note_on, note_num, velocity
//                     event payload, sampled only in the handshake cycle
//                     (note-on with velocity 0 is a note-off)
//   all_notes_off     pulse: drop all gates, abort any event in flight
//   voice_idle        per voice: envelope has finished its release
//   voice_gate        per-voice gate
//   voice_note_flat   note of voice i at [i*NOTE_WIDTH +: NOTE_WIDTH]
//   voice_vel_flat    velocity of voice i, packed the same way
//   voice_trigger     one-cycle envelope (re)start pulse per voice
//   steal_pulse       one-cycle pulse when a gated voice was stolen
//   active_count      registered count of gated voices
// ---------------------------------------------------------------------------
module voice_allocator #(
   parameter int NUM_VOICES = 8,
   parameter int NOTE_WIDTH = 7,
   parameter int VEL_WIDTH  = 7,
   parameter int AGE_WIDTH  = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             note_valid,
   output logic                             note_ready,
   input  logic                             note_on,
   input  logic [NOTE_WIDTH-1:0]            note_num,
   input  logic [VEL_WIDTH-1:0]             velocity,
   input  logic                             all_notes_off,
   input  logic [NUM_VOICES-1:0]            voice_idle,
   output logic [NUM_VOICES-1:0]            voice_gate,
   output logic [NOTE_WIDTH*NUM_VOICES-1:0] voice_note_flat,
   output logic [VEL_WIDTH*NUM_VOICES-1:0]  voice_vel_flat,
   output logic [NUM_VOICES-1:0]            voice_trigger,
   output logic                             steal_pulse,
   output logic [$clog2(NUM_VOICES+1)-1:0]  active_count
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int CNT_W = $clog2(NUM_VOICES+1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_APPLY  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      ACT_NONE   = 3'd0,
      ACT_RETRIG = 3'd1,
      ACT_FREE   = 3'd2,
      ACT_REL    = 3'd3,
      ACT_STEAL  = 3'd4,
      ACT_OFF    = 3'd5
   } action_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   // captured event
   logic                    r_ev_on;
   logic [NOTE_WIDTH-1:0]   r_ev_note;
   logic [VEL_WIDTH-1:0]    r_ev_vel;

   // decision registered at the end of LOOKUP
   action_t                 r_action;
   logic [IDX_W-1:0]        r_target;
   action_t                 w_action;
   logic [IDX_W-1:0]        w_target;

   // voice state
   logic [NUM_VOICES-1:0]   r_gate;
   logic [NOTE_WIDTH-1:0]   r_note [NUM_VOICES];
   logic [VEL_WIDTH-1:0]    r_vel  [NUM_VOICES];
   logic [AGE_WIDTH-1:0]    r_age  [NUM_VOICES];
   logic [NUM_VOICES-1:0]   r_trigger;
   logic                    r_steal;
   logic [CNT_W-1:0]        r_active_count;

   // candidate search results
   logic                    w_match_hit;
   logic [IDX_W-1:0]        w_match_idx;
   logic                    w_free_hit;
   logic [IDX_W-1:0]        w_free_idx;
   logic                    w_rel_hit;
   logic [IDX_W-1:0]        w_rel_idx;
   logic [AGE_WIDTH-1:0]    w_rel_age;
   logic                    w_held_hit;
   logic [IDX_W-1:0]        w_held_idx;
   logic [AGE_WIDTH-1:0]    w_held_age;
   logic [CNT_W-1:0]        w_gate_count;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      note_ready  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            note_ready = 1'b1;
            if (note_valid) w_state_nxt = ST_LOOKUP;
         end
         ST_LOOKUP: w_state_nxt = ST_APPLY;
         ST_APPLY:  w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
      // all_notes_off wins over everything, including a same-cycle handshake
      if (all_notes_off) w_state_nxt = ST_IDLE;
   end

   // ---------------- event capture ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ev_on   <= 1'b0;
         r_ev_note <= '0;
         r_ev_vel  <= '0;
      end else if (r_state == ST_IDLE && note_valid) begin
         r_ev_on   <= note_on && (velocity != '0);
         r_ev_note <= note_num;
         r_ev_vel  <= velocity;
      end
   end

   // ---------------- candidate search (ascending: ties go to lowest index) ----
   always_comb begin
      w_match_hit = 1'b0;
      w_match_idx = '0;
      w_free_hit  = 1'b0;
      w_free_idx  = '0;
      w_rel_hit   = 1'b0;
      w_rel_idx   = '0;
      w_rel_age   = '0;
      w_held_hit  = 1'b0;
      w_held_idx  = '0;
      w_held_age  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (r_gate[i] && (r_note[i] == r_ev_note) && !w_match_hit) begin
            w_match_hit = 1'b1;
            w_match_idx = IDX_W'(i);
         end
         if (!r_gate[i] && voice_idle[i] && !w_free_hit) begin
            w_free_hit = 1'b1;
            w_free_idx = IDX_W'(i);
         end
         if (!r_gate[i] && !voice_idle[i] && (!w_rel_hit || (r_age[i] > w_rel_age))) begin
            w_rel_hit = 1'b1;
            w_rel_idx = IDX_W'(i);
            w_rel_age = r_age[i];
         end
         if (r_gate[i] && (!w_held_hit || (r_age[i] > w_held_age))) begin
            w_held_hit = 1'b1;
            w_held_idx = IDX_W'(i);
            w_held_age = r_age[i];
         end
      end
   end

   // If no voice is free or releasing, every voice is gated, so the steal
   // candidate always exists.
   always_comb begin
      w_action = ACT_NONE;
      w_target = '0;
      if (r_ev_on) begin
         if (w_match_hit) begin
            w_action = ACT_RETRIG;
            w_target = w_match_idx;
         end else if (w_free_hit) begin
            w_action = ACT_FREE;
            w_target = w_free_idx;
         end else if (w_rel_hit) begin
            w_action = ACT_REL;
            w_target = w_rel_idx;
         end else begin
            w_action = ACT_STEAL;
            w_target = w_held_idx;
         end
      end else if (w_match_hit) begin
         w_action = ACT_OFF;
         w_target = w_match_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_action <= ACT_NONE;
         r_target <= '0;
      end else if (r_state == ST_LOOKUP) begin
         r_action <= w_action;
         r_target <= w_target;
      end
   end

   // ---------------- voice update ----------------
   always_ff @(posedge clk) begin
      r_trigger <= '0;
      r_steal   <= 1'b0;
      if (rst) begin
         r_gate <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_note[i] <= '0;
            r_vel[i]  <= '0;
            r_age[i]  <= '0;
         end
      end else if (all_notes_off) begin
         r_gate <= '0;
      end else if (r_state == ST_APPLY) begin
         case (r_action)
            ACT_NONE: ;
            ACT_OFF:  r_gate[r_target] <= 1'b0;
            default: begin
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (i == int'(r_target)) begin
                     r_gate[i] <= 1'b1;
                     r_note[i] <= r_ev_note;
                     r_vel[i]  <= r_ev_vel;
                     r_age[i]  <= '0;
                  end else if (r_age[i] != '1) begin
                     r_age[i]  <= r_age[i] + AGE_WIDTH'(1);
                  end
               end
               r_trigger[r_target] <= 1'b1;
               r_steal             <= (r_action == ACT_STEAL);
            end
         endcase
      end
   end

   // ---------------- active count (one cycle behind the gates) ----------------
   always_comb begin
      w_gate_count = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         w_gate_count = w_gate_count + CNT_W'(r_gate[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) r_active_count <= '0;
      else     r_active_count <= w_gate_count;
   end

   // ---------------- outputs ----------------
   always_comb begin
      voice_note_flat = '0;
      voice_vel_flat  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         voice_note_flat[i*NOTE_WIDTH +: NOTE_WIDTH] = r_note[i];
         voice_vel_flat[i*VEL_WIDTH +: VEL_WIDTH]    = r_vel[i];
      end
   end

   assign voice_gate    = r_gate;
   assign voice_trigger = r_trigger;
   assign steal_pulse   = r_steal;
   assign active_count  = r_active_count;

endmodule
